// File: rtl/ofifo_drain_ctrl_pkg.sv
// Shared types and sizing helpers for the output-FIFO drain controller.
package ofifo_drain_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int OCC_W_DEF = occ_width(64);

endpackage

// File: rtl/ofifo_drain_ctrl_occ_counter.sv
// Saturating FIFO row-occupancy counter with a sticky overflow flag.
module ofifo_occ_counter
  import ofifo_drain_ctrl_pkg::*;
#(
  parameter int fifo_depth = 64,
  parameter int occ_bw     = OCC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_clr_ovf,
  output logic [occ_bw-1:0] o_occ,
  output logic              o_overflow
);

  localparam logic [occ_bw-1:0] DEPTH = occ_bw'(fifo_depth);

  logic [occ_bw-1:0] r_occ;
  logic              r_ovf;
  logic              w_push_full;

  assign w_push_full = i_push && !i_pop && (r_occ == DEPTH);

  // A simultaneous push and pop leaves the count alone, even when full.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (i_push && !i_pop && (r_occ != DEPTH))
        r_occ <= r_occ + 1'b1;
      else if (i_pop && !i_push && (r_occ != '0))
        r_occ <= r_occ - 1'b1;

      if (w_push_full)
        r_ovf <= 1'b1;
      else if (i_clr_ovf)
        r_ovf <= 1'b0;
    end
  end

  assign o_occ      = r_occ;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/ofifo_drain_ctrl.sv
// Drains full rows from the output psum FIFO into sequential psum SRAM addresses.
module ofifo_drain_ctrl
  import ofifo_drain_ctrl_pkg::*;
#(
  parameter int col        = 8,
  parameter int psum_bw    = 16,
  parameter int addr_bw    = 11,
  parameter int fifo_depth = 64,
  parameter int cnt_bw     = 11
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_start,
  input  logic [addr_bw-1:0]                  i_base_addr,
  input  logic [cnt_bw-1:0]                   i_num_vec,
  input  logic                                i_ofifo_row_vld,
  input  logic                                i_ofifo_full,
  input  logic [col*psum_bw-1:0]              i_ofifo_data,
  input  logic                                i_sram_ready,
  output logic                                o_ofifo_rd,
  output logic                                o_sram_wen,
  output logic [addr_bw-1:0]                  o_sram_addr,
  output logic [col*psum_bw-1:0]              o_sram_wdata,
  output logic [occ_width(fifo_depth)-1:0]    o_occupancy,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_overflow
);

  localparam int OCC_W = occ_width(fifo_depth);

  state_t             r_state;
  logic [cnt_bw-1:0]  r_num_vec;
  logic [cnt_bw-1:0]  r_issued;
  logic [addr_bw-1:0] r_base;
  logic [addr_bw-1:0] r_addr_p1;
  logic               r_wen_p1;
  logic               r_busy;
  logic               r_done;

  logic [OCC_W-1:0]   w_occ;
  logic               w_rd_p0;
  logic               w_start_acc;
  logic               w_last;
  logic               w_unused_full;

  // Full flag is informational; reads are bounded by the tracked occupancy.
  assign w_unused_full = i_ofifo_full;

  assign w_start_acc = (r_state == IDLE) && i_start;
  assign w_last      = (r_issued == (r_num_vec - cnt_bw'(1)));
  assign w_rd_p0     = (r_state == DRAIN) && (w_occ != '0) && i_sram_ready &&
                       (r_issued < r_num_vec);

  ofifo_occ_counter #(
    .fifo_depth (fifo_depth),
    .occ_bw     (OCC_W)
  ) u_occ (
    .clk        (clk),
    .reset      (reset),
    .i_push     (i_ofifo_row_vld),
    .i_pop      (w_rd_p0),
    .i_clr_ovf  (w_start_acc),
    .o_occ      (w_occ),
    .o_overflow (o_overflow)
  );

  // Tile parameters are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_start_acc) begin
      r_base    <= i_base_addr;
      r_num_vec <= i_num_vec;
    end
  end

  // p0 -> p1: a read issued now becomes the SRAM write on the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_issued  <= '0;
      r_addr_p1 <= '0;
      r_wen_p1  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_wen_p1 <= w_rd_p0;
      r_done   <= 1'b0;
      if (w_rd_p0) begin
        r_addr_p1 <= r_base + addr_bw'(r_issued);
        r_issued  <= r_issued + 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_issued <= '0;
            r_busy   <= 1'b1;
            if (i_num_vec == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_rd_p0 && w_last)
            r_state <= WAIT;
        end
        WAIT: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ofifo_rd   = w_rd_p0;
  assign o_sram_wen   = r_wen_p1;
  assign o_sram_addr  = r_addr_p1;
  assign o_sram_wdata = i_ofifo_data;
  assign o_occupancy  = w_occ;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
// Scoreboard bench: a queue-based FIFO/tile model predicts reads, writes, done and occupancy.
module tb_ofifo_drain_ctrl;

  localparam int DEPTH = 64;
  localparam int DW    = 128;
  localparam int BIG   = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [10:0]   base = '0;
  logic [10:0]   nv = '0;
  logic          row_vld = 1'b0;
  logic          ofull;
  logic [DW-1:0] odata = '0;
  logic          ready = 1'b1;
  logic          ofifo_rd, sram_wen, busy, done, overflow;
  logic [10:0]   sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [6:0]    occupancy;

  always #5 clk = ~clk;

  ofifo_drain_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .i_start         (start),
    .i_base_addr     (base),
    .i_num_vec       (nv),
    .i_ofifo_row_vld (row_vld),
    .i_ofifo_full    (ofull),
    .i_ofifo_data    (odata),
    .i_sram_ready    (ready),
    .o_ofifo_rd      (ofifo_rd),
    .o_sram_wen      (sram_wen),
    .o_sram_addr     (sram_addr),
    .o_sram_wdata    (sram_wdata),
    .o_occupancy     (occupancy),
    .o_busy          (busy),
    .o_done          (done),
    .o_overflow      (overflow)
  );

  assign ofull = (occupancy == 7'd64);

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_wen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [10:0]   exp_addr[$];
  bit            m_ovf = 0;
  int            bs = BIG, be = -1, rem = 0, exp_done = -1;
  bit            wen_exp = 0, chk_reset = 0, exp_busy, exp_rd;
  logic [10:0]   wen_addr = '0;
  logic [DW-1:0] wen_data = '0;
  logic [DW-1:0] data_nxt = '0;

  always @(posedge clk) begin
    #1;
    odata = data_nxt;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare DUT against model, then advance model with this cycle's inputs
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_busy = (cyc >= bs) && (cyc <= be);
      exp_rd   = (cyc >= bs) && (rem > 0) && (mq.size() > 0) && ready;
      check("occupancy", DW'(occupancy), DW'(mq.size()));
      check("overflow", DW'(overflow), DW'(m_ovf));
      check("busy", DW'(busy), DW'(exp_busy));
      check("done", DW'(done), DW'(cyc == exp_done));
      check("ofifo_rd", DW'(ofifo_rd), DW'(exp_rd));
      check("sram_wen", DW'(sram_wen), DW'(wen_exp));
      if (sram_wen) n_wen++;
      if (sram_wen && wen_exp) begin
        check("sram_addr", DW'(sram_addr), DW'(wen_addr));
        check("sram_wdata", sram_wdata, wen_data);
      end
      if (chk_reset) check("reset_addr", DW'(sram_addr), '0);
      chk_reset = 0;
      wen_exp = 0;
      if (reset) begin
        mq.delete();
        exp_addr.delete();
        m_ovf = 0; bs = BIG; be = -1; rem = 0; exp_done = -1;
        chk_reset = 1;
      end else begin
        if (exp_rd) begin
          wen_exp  = 1;
          wen_data = mq.pop_front();
          data_nxt = wen_data;
          if (exp_addr.size() > 0) wen_addr = exp_addr.pop_front();
          rem--;
          if (rem == 0) begin
            exp_done = cyc + 2;
            be = cyc + 2;
          end
        end
        if (start && !exp_busy) begin
          m_ovf = 0;
          bs = cyc + 1;
          rem = int'(nv);
          exp_addr.delete();
          for (int k = 0; k < int'(nv); k++) exp_addr.push_back(base + 11'(k));
          if (nv == 0) begin
            exp_done = cyc + 1;
            be = cyc + 1;
          end else begin
            be = BIG;
          end
        end
        if (row_vld) begin
          if (mq.size() < DEPTH) mq.push_back({$urandom, $urandom, $urandom, $urandom});
          else m_ovf = 1;
        end
      end
    end
  end

  task automatic step(input bit v, input bit r, input bit s, input logic [10:0] b,
                      input logic [10:0] n);
    row_vld = v; ready = r; start = s; base = b; nv = n;
    @(posedge clk);
    #1;
    row_vld = 0; start = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, base, nv);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy && n < maxc) begin
      step(0, 1, 0, base, nv);
      n++;
    end
    if (busy) begin
      tests++; fails++;
      $display("FAIL wait_idle cyc=%0d got=busy want=idle", cyc);
    end
    idle(1);
  endtask

  initial begin
    #3;
    idle(3);
    reset = 0;
    idle(1);

    // 1: rows pushed while idle, back-to-back drain
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 11'h010, 11'd4);
    wait_idle(40);

    // 2: FIFO starts empty, rows trickle in
    step(0, 1, 1, 11'h050, 11'd3);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, base, nv);
      idle(2);
    end
    wait_idle(40);

    // 3: SRAM back-pressure mid-drain
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 11'h200, 11'd8);
    idle(3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, base, nv);
    wait_idle(40);

    // 4: concurrent push/read at occupancy 1, then saturation and overflow
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 11'h300, 11'd3);
    step(1, 1, 0, base, nv);
    step(1, 1, 0, base, nv);
    wait_idle(40);
    for (int i = 0; i < 65; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 11'h100, 11'd64);
    wait_idle(200);

    // 5: zero-length tile, then a start while busy
    step(0, 1, 1, 11'h020, 11'd0);
    wait_idle(10);
    step(0, 1, 1, 11'h030, 11'd2);
    step(0, 1, 1, 11'h040, 11'd5);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    wait_idle(40);

    // 6: reset mid-drain, then address wrap
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    begin
      int tgt = n_wen + 4;
      int k = 0;
      step(0, 1, 1, 11'h400, 11'd10);
      while (n_wen < tgt && k < 50) begin
        step(0, 1, 0, base, nv);
        k++;
      end
    end
    reset = 1;
    step(0, 1, 0, 0, 0);
    reset = 0;
    idle(2);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    step(0, 1, 1, 11'h7FE, 11'd4);
    wait_idle(40);

    // Randomized tiles with random pushes and back-pressure
    for (int it = 0; it < 20; it++) begin
      int pre = $urandom_range(0, 3);
      int n = 0;
      for (int i = 0; i < pre; i++) step(1, 1, 0, 0, 0);
      step(0, 1, 1, 11'($urandom), 11'($urandom_range(1, 6)));
      while (busy && n < 300) begin
        step(($urandom_range(0, 1) == 1) && (occupancy < 7'd40),
             $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
             11'($urandom), 11'($urandom_range(0, 6)));
        n++;
      end
      if (busy) begin
        tests++; fails++;
        $display("FAIL rand_tile cyc=%0d got=busy want=idle", cyc);
      end
      idle(1);
    end

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
